// File: rtl/rssi_meas_sched.sv
// rtl/rssi_meas_sched.sv - round-robin scheduler for the shared RSSI measurement window (optional RSSI_MEAS_TIMEOUT_EN)
module rssi_meas_sched #(
   parameter int IQ_DATA_WIDTH = 16,
   parameter int LOG2_MAX_WIN  = 10,
   parameter int SETTLE_LEN    = 32
`ifdef RSSI_MEAS_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IQ_DATA_WIDTH-1:0] iq_rssi,
   input  logic                     iq_rssi_valid,
   input  logic                     req0,
   input  logic [3:0]               req0_log2_win,
   input  logic                     req1,
   input  logic [3:0]               req1_log2_win,
   input  logic                     abort,
   output logic                     gnt0,
   output logic                     gnt1,
   output logic                     busy,
   output logic [IQ_DATA_WIDTH-1:0] meas_avg,
   output logic [IQ_DATA_WIDTH-1:0] meas_max,
   output logic                     meas_owner,
   output logic                     meas_done
`ifdef RSSI_MEAS_TIMEOUT_EN
   ,
   output logic                     meas_timeout
`endif
);

   localparam int ACC_W       = IQ_DATA_WIDTH + LOG2_MAX_WIN;
   localparam int SET_W       = $clog2(SETTLE_LEN + 1);
   localparam int CNT_W       = (LOG2_MAX_WIN + 1 > SET_W) ? LOG2_MAX_WIN + 1 : SET_W;
   localparam int SETTLE_LAST = (SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0;
   localparam logic [3:0] MAX_WIN = 4'(LOG2_MAX_WIN);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_ACCUM  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                   state_q;
   logic                     last_q;      // port served by the most recent grant
   logic                     owner_q;     // owner of the running measurement
   logic [3:0]               win_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [ACC_W-1:0]         acc_q;
   logic [IQ_DATA_WIDTH-1:0] max_q;

   logic                     gnt0_q;
   logic                     gnt1_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     owner_o_q;
   logic [IQ_DATA_WIDTH-1:0] avg_q;
   logic [IQ_DATA_WIDTH-1:0] max_o_q;

   logic                     pick1_d;
   logic [3:0]               win_sel_d;
   logic [3:0]               win_clamp_d;
   logic [IQ_DATA_WIDTH-1:0] samp_d;
   logic [ACC_W-1:0]         acc_d;
   logic [IQ_DATA_WIDTH-1:0] max_d;
   logic [IQ_DATA_WIDTH-1:0] avg_d;
   logic                     cnt_last_d;

`ifdef RSSI_MEAS_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCW-1:0]           tcnt_q;
   logic                     timeout_q;
   logic                     tmo_hit_d;
   logic [IQ_DATA_WIDTH-1:0] avg_part_d;
`endif

   // Arbitration winner, clamped window, and the datapath result of the current sample
   always_comb begin
      pick1_d     = req1 & (~req0 | ~last_q);
      win_sel_d   = pick1_d ? req1_log2_win : req0_log2_win;
      win_clamp_d = (win_sel_d > MAX_WIN) ? MAX_WIN : win_sel_d;
      samp_d      = iq_rssi[IQ_DATA_WIDTH-1] ? '0 : iq_rssi;
      acc_d       = acc_q + ACC_W'(samp_d);
      max_d       = (samp_d > max_q) ? samp_d : max_q;
      avg_d       = IQ_DATA_WIDTH'(acc_d >> win_q);
      cnt_last_d  = (cnt_q == ((CNT_W'(1) << win_q) - CNT_W'(1)));
`ifdef RSSI_MEAS_TIMEOUT_EN
      tmo_hit_d   = ~iq_rssi_valid & (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));
      avg_part_d  = IQ_DATA_WIDTH'(acc_q >> win_q);
`endif
   end

   // Measurement FSM with registered grant, busy and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         win_q     <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         max_q     <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         owner_o_q <= 1'b0;
         avg_q     <= '0;
         max_o_q   <= '0;
`ifdef RSSI_MEAS_TIMEOUT_EN
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req0 | req1) begin
                  gnt0_q  <= ~pick1_d;
                  gnt1_q  <= pick1_d;
                  last_q  <= pick1_d;
                  owner_q <= pick1_d;
                  win_q   <= win_clamp_d;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  max_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (SETTLE_LEN == 0) ? S_ACCUM : S_SETTLE;
`ifdef RSSI_MEAS_TIMEOUT_EN
                  tcnt_q    <= '0;
                  timeout_q <= 1'b0;
`endif
               end
            end
            S_SETTLE, S_ACCUM: begin
`ifdef RSSI_MEAS_TIMEOUT_EN
               tcnt_q <= iq_rssi_valid ? '0 : tcnt_q + TCW'(1);
`endif
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (iq_rssi_valid) begin
                  if (state_q == S_SETTLE) begin
                     if (cnt_q == CNT_W'(SETTLE_LAST)) begin
                        cnt_q   <= '0;
                        state_q <= S_ACCUM;
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end else begin
                     acc_q <= acc_d;
                     max_q <= max_d;
                     if (cnt_last_d) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        avg_q     <= avg_d;
                        max_o_q   <= max_d;
                        owner_o_q <= owner_q;
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
               end
`ifdef RSSI_MEAS_TIMEOUT_EN
               else if (tmo_hit_d) begin
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  avg_q     <= avg_part_d;
                  max_o_q   <= max_q;
                  owner_o_q <= owner_q;
               end
`endif
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign busy       = busy_q;
   assign meas_avg   = avg_q;
   assign meas_max   = max_o_q;
   assign meas_owner = owner_o_q;
   assign meas_done  = done_q;
`ifdef RSSI_MEAS_TIMEOUT_EN
   assign meas_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_rssi_meas_sched.sv
// tb/tb_rssi_meas_sched.sv - directed and randomized bench for rssi_meas_sched
module tb_rssi_meas_sched;
   localparam int W   = 16;
   localparam int LMW = 10;
   localparam int SL  = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] iq_rssi;
   logic         iq_rssi_valid;
   logic         req0, req1, abort;
   logic [3:0]   req0_log2_win, req1_log2_win;
   logic         gnt0, gnt1, busy, meas_owner, meas_done;
   logic [W-1:0] meas_avg, meas_max;
`ifdef RSSI_MEAS_TIMEOUT_EN
   logic         meas_timeout;
`endif

   int tests  = 0;
   int failed = 0;
   int samples[$];
   int last_srv;
   int prev_avg, prev_max, prev_owner;

   always #5 clk = ~clk;

   rssi_meas_sched #(
      .IQ_DATA_WIDTH(W),
      .LOG2_MAX_WIN(LMW),
      .SETTLE_LEN(SL)
`ifdef RSSI_MEAS_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .iq_rssi(iq_rssi),
      .iq_rssi_valid(iq_rssi_valid),
      .req0(req0),
      .req0_log2_win(req0_log2_win),
      .req1(req1),
      .req1_log2_win(req1_log2_win),
      .abort(abort),
      .gnt0(gnt0),
      .gnt1(gnt1),
      .busy(busy),
      .meas_avg(meas_avg),
      .meas_max(meas_max),
      .meas_owner(meas_owner),
      .meas_done(meas_done)
`ifdef RSSI_MEAS_TIMEOUT_EN
      ,
      .meas_timeout(meas_timeout)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_winner(input logic r0, input logic r1);
      if (r0 && r1) return 1 - last_srv;
      return r1 ? 1 : 0;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ":gnt"}, {gnt1, gnt0}, 0);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":avg"}, meas_avg, 0);
      check({tag, ":max"}, meas_max, 0);
      check({tag, ":owner"}, meas_owner, 0);
      check({tag, ":done"}, meas_done, 0);
   endtask

   task automatic wait_grant(input string tag, output int port, output int n);
      bit found;
      int exp_p;
      found = 0;
      n = 0;
      exp_p = exp_winner(req0, req1);
      port = exp_p;
      while (!found && n < 8) begin
         tick();
         n++;
         if (gnt0 || gnt1) found = 1;
      end
      check({tag, ":gnt_seen"}, found, 1);
      if (found) begin
         check({tag, ":gnt_port"}, {gnt1, gnt0}, (exp_p == 1) ? 2 : 1);
         check({tag, ":busy_gnt"}, busy, 1);
      end
      last_srv = exp_p;
   endtask

   task automatic fill_random(input int win_in);
      logic signed [W-1:0] sv;
      int nwin;
      nwin = 1 << ((win_in > LMW) ? LMW : win_in);
      samples.delete();
      for (int i = 0; i < nwin; i++) begin
         sv = W'($urandom);
         samples.push_back(int'(sv));
      end
   endtask

   task automatic run_window(input string tag, input int port, input int win_in,
                             input int settle_val, input bit gap, input bit abort_last);
      int weff, nwin, v, mx;
      longint sum;
      logic [3:0] w0, w1;
      weff = (win_in > LMW) ? LMW : win_in;
      nwin = 1 << weff;
      sum = 0;
      mx = 0;
      w0 = req0_log2_win;
      w1 = req1_log2_win;
      req0_log2_win = 4'($urandom);
      req1_log2_win = 4'($urandom);
      for (int k = 0; k < SL; k++) begin
         if (gap && $urandom_range(0, 3) == 0) begin
            iq_rssi_valid = 1'b0;
            iq_rssi = W'($urandom);
            tick();
         end
         iq_rssi_valid = 1'b1;
         iq_rssi = (settle_val < 0) ? W'($urandom) : W'(settle_val);
         tick();
         if (k == 0) check({tag, ":gnt_pulse"}, {gnt1, gnt0}, 0);
      end
      for (int i = 0; i < nwin; i++) begin
         if (gap && $urandom_range(0, 3) == 0) begin
            iq_rssi_valid = 1'b0;
            iq_rssi = W'($urandom);
            tick();
         end
         v = samples[i];
         iq_rssi = W'(v);
         iq_rssi_valid = 1'b1;
         if (v > 0) sum += v;
         if (v > mx) mx = v;
         abort = abort_last && (i == nwin - 1);
         tick();
      end
      iq_rssi_valid = 1'b0;
      abort = 1'b0;
      req0_log2_win = w0;
      req1_log2_win = w1;
      if (abort_last) begin
         check({tag, ":ab_done"}, meas_done, 0);
         check({tag, ":ab_busy"}, busy, 0);
         check({tag, ":ab_avg"}, meas_avg, prev_avg);
         check({tag, ":ab_max"}, meas_max, prev_max);
         check({tag, ":ab_owner"}, meas_owner, prev_owner);
         tick();
         check({tag, ":ab_done2"}, meas_done, 0);
      end else begin
         check({tag, ":done"}, meas_done, 1);
         check({tag, ":avg"}, meas_avg, sum >> weff);
         check({tag, ":max"}, meas_max, mx);
         check({tag, ":owner"}, meas_owner, port);
         check({tag, ":busy_done"}, busy, 1);
`ifdef RSSI_MEAS_TIMEOUT_EN
         check({tag, ":timeout"}, meas_timeout, 0);
`endif
         prev_avg = int'(sum >> weff);
         prev_max = mx;
         prev_owner = port;
         tick();
         check({tag, ":done_pulse"}, meas_done, 0);
         check({tag, ":busy_gap"}, busy, 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, n;
      int sel;
      logic [3:0] wsel;
      rst = 1'b1;
      iq_rssi = '0;
      iq_rssi_valid = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      abort = 1'b0;
      req0_log2_win = '0;
      req1_log2_win = '0;
      last_srv = 1;
      prev_avg = 0;
      prev_max = 0;
      prev_owner = 0;

      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      // basic window; abort in IDLE must not block the grant
      req0 = 1'b1;
      req0_log2_win = 4'd2;
      req1_log2_win = 4'd7;
      abort = 1'b1;
      wait_grant("t1", p, n);
      check("t1:latency", n, 1);
      req0 = 1'b0;
      abort = 1'b0;
      samples = '{10, 20, 30, 40};
      run_window("t1", p, 2, 999, 1'b0, 1'b0);

      // both requests held from reset: alternating grants
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_srv = 1;
      prev_avg = 0;
      prev_max = 0;
      prev_owner = 0;
      req0 = 1'b1;
      req1 = 1'b1;
      req0_log2_win = 4'd3;
      req1_log2_win = 4'd1;
      for (int m = 0; m < 3; m++) begin
         wait_grant("t2", p, n);
         check("t2:latency", n, 1);
         check("t2:order", p, m % 2);
         fill_random((p == 1) ? 1 : 3);
         run_window("t2", p, (p == 1) ? 1 : 3, -1, 1'b1, 1'b0);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();

      // oversized window exponent is clamped, full-scale input
      req1 = 1'b1;
      req1_log2_win = 4'd15;
      wait_grant("t3", p, n);
      req1 = 1'b0;
      samples.delete();
      for (int i = 0; i < 1024; i++) samples.push_back(32767);
      run_window("t3", p, 15, -1, 1'b0, 1'b0);

      // negative samples clamp to zero
      req0 = 1'b1;
      req0_log2_win = 4'd1;
      wait_grant("t4", p, n);
      req0 = 1'b0;
      samples = '{-5, -5};
      run_window("t4", p, 1, -1, 1'b0, 1'b0);

      // randomized requests, windows, gaps and signed samples
      for (int r = 0; r < 6; r++) begin
         sel = $urandom_range(1, 3);
         req0 = sel[0];
         req1 = sel[1];
         req0_log2_win = 4'($urandom_range(0, 5));
         req1_log2_win = 4'($urandom_range(0, 5));
         wait_grant("t5", p, n);
         wsel = (p == 1) ? req1_log2_win : req0_log2_win;
         req0 = 1'b0;
         req1 = 1'b0;
         fill_random(int'(wsel));
         run_window("t5", p, int'(wsel), -1, 1'b1, 1'b0);
      end

      // abort coincident with the last accumulate sample
      req1 = 1'b1;
      req1_log2_win = 4'd2;
      wait_grant("t6", p, n);
      req1 = 1'b0;
      fill_random(2);
      run_window("t6", p, 2, -1, 1'b0, 1'b1);

      // abort mid-settle; pointer keeps the aborted grant
      req0 = 1'b1;
      req0_log2_win = 4'd1;
      wait_grant("t6b", p, n);
      req0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         iq_rssi_valid = 1'b1;
         iq_rssi = W'($urandom);
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      iq_rssi_valid = 1'b0;
      check("t6b:busy", busy, 0);
      check("t6b:done", meas_done, 0);
      tick();
      check("t6b:avg", meas_avg, prev_avg);
      req0 = 1'b1;
      req1 = 1'b1;
      req1_log2_win = 4'd0;
      wait_grant("t6c", p, n);
      check("t6c:port", p, 1);
      req0 = 1'b0;
      req1 = 1'b0;
      fill_random(0);
      run_window("t6c", p, 0, -1, 1'b0, 1'b0);

      // reset mid-settle, held request re-arbitrated afterwards
      req1 = 1'b1;
      req1_log2_win = 4'd2;
      wait_grant("t7", p, n);
      for (int k = 0; k < 4; k++) begin
         iq_rssi_valid = 1'b1;
         iq_rssi = W'($urandom);
         tick();
      end
      iq_rssi_valid = 1'b0;
      rst = 1'b1;
      tick();
      check_all_zero("t7_rst");
      rst = 1'b0;
      last_srv = 1;
      prev_avg = 0;
      prev_max = 0;
      prev_owner = 0;
      wait_grant("t7b", p, n);
      check("t7b:latency", n, 1);
      req1 = 1'b0;
      fill_random(2);
      run_window("t7b", p, 2, -1, 1'b1, 1'b0);

`ifdef RSSI_MEAS_TIMEOUT_EN
      // stalled sample stream ends the window by timeout
      req0 = 1'b1;
      req0_log2_win = 4'd2;
      wait_grant("t8", p, n);
      req0 = 1'b0;
      for (int k = 0; k < SL; k++) begin
         iq_rssi_valid = 1'b1;
         iq_rssi = W'(500);
         tick();
      end
      iq_rssi = W'(8);
      tick();
      iq_rssi = W'(4);
      tick();
      iq_rssi_valid = 1'b0;
      begin
         bit seen;
         int cyc;
         seen = 0;
         cyc = 0;
         while (!seen && cyc < 300) begin
            tick();
            cyc++;
            if (meas_done) seen = 1;
         end
         check("t8:done_seen", seen, 1);
      end
      check("t8:timeout", meas_timeout, 1);
      check("t8:avg", meas_avg, 3);
      check("t8:max", meas_max, 8);
      check("t8:owner", meas_owner, 0);
      tick();
      req1 = 1'b1;
      wait_grant("t8b", p, n);
      req1 = 1'b0;
      check("t8b:tmo_clear", meas_timeout, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/rssi_meas_sched.md
Name: rssi_meas_sched

Overview:
- Schedules and shares the RSSI measurement path (DC removal -> |I|,|Q| -> 32-tap moving average -> iq_rssi) between two requesters: CCA/CSMA logic on port 0, software/channel-scan on port 1.
- Round-robin arbitration; per-grant measurement window runs as settle (discard) then accumulate.
- Reports window average, window peak and owner id with a done pulse.

Parameters:
- IQ_DATA_WIDTH, 16, width of iq_rssi and of meas_avg/meas_max.
- LOG2_MAX_WIN, 10, largest accepted window exponent; accumulator width = IQ_DATA_WIDTH+LOG2_MAX_WIN.
- SETTLE_LEN, 32, valid samples discarded after grant so the moving average refills; 0 = no settle phase.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active high.
- iq_rssi  in  IQ_DATA_WIDTH  signed averaged RSSI sample.
- iq_rssi_valid  in  1  sample strobe.
- req0  in  1  level request, port 0.
- req0_log2_win  in  4  window exponent for port 0, sampled at grant.
- req1  in  1  level request, port 1.
- req1_log2_win  in  4  window exponent for port 1, sampled at grant.
- abort  in  1  cancels the running measurement.
- gnt0  out  1  one-cycle grant pulse, port 0.
- gnt1  out  1  one-cycle grant pulse, port 1.
- busy  out  1  high in every state except IDLE.
- meas_avg  out  IQ_DATA_WIDTH  window mean.
- meas_max  out  IQ_DATA_WIDTH  window peak.
- meas_owner  out  1  port id of the result.
- meas_done  out  1  one-cycle result strobe.

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer favours port 0, accumulator/counters cleared.
- States: IDLE -> SETTLE -> ACCUM -> DONE -> IDLE. All outputs are registered.
- IDLE, any req high: the next cycle enters SETTLE (or ACCUM if SETTLE_LEN=0) with the winner's gntN=1 for exactly that cycle.
  - Winner's log2_win is latched, clamped to LOG2_MAX_WIN.
  - Owner is latched; accumulator, max and counters clear.
- Arbitration:
  - Only one req high: it wins.
  - Both high: the port not served last wins. After reset with both high, port 0 wins.
  - Pointer updates at each grant.
- Requests:
  - req may stay high in the gnt cycle; it is ignored while busy.
  - req still high on return to IDLE counts as a new request.
- SETTLE: counts iq_rssi_valid cycles only. After the SETTLE_LEN-th valid sample, the next cycle is ACCUM. Samples are discarded.
- ACCUM, per valid sample:
  - Negative iq_rssi is clamped to 0.
  - Clamped value is added to the unsigned accumulator; max updates if greater.
  - After the 2^log2_win-th valid sample (log2_win=0 -> 1 sample), go to DONE.
  - Invalid cycles do nothing.
- DONE (one cycle):
  - meas_done=1.
  - meas_avg = accumulator >> log2_win (exact, no overflow, by width rule); meas_max and meas_owner presented.
  - meas_avg/max/owner hold until the next DONE.
  - Next state IDLE; earliest next grant is 2 cycles after the done cycle.
- abort in SETTLE/ACCUM:
  - Next state IDLE, no meas_done.
  - Result outputs keep their previous values; RR pointer is not rolled back.
  - abort in IDLE or DONE is ignored; DONE completes.
- abort on the same cycle as the final ACCUM sample: abort wins, no done.
- rst mid-measurement: immediate return to reset values; a pending req is re-arbitrated after rst deasserts.

Optional Feature:
- Macro RSSI_MEAS_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 4096) and output meas_timeout (1 bit).
  - A cycle counter clears on every iq_rssi_valid and on grant.
  - If it reaches TIMEOUT_CYCLES in SETTLE/ACCUM, go to DONE with meas_timeout=1. meas_avg/meas_max then report partial accumulator >> log2_win and partial max; 0 if no ACCUM sample.
  - meas_timeout clears at the next grant.
  - abort has priority over timeout.
- Undefined: no counter, no port; a stalled valid stream keeps the block busy until abort or rst.

Test Plan:
- req0=1, log2_win=2, SETTLE_LEN=32, iq_rssi valid every cycle:
  - 32 samples of 999 discarded, then 10,20,30,40 -> gnt0 one cycle; meas_done 1 cycle after the 40; meas_avg=25, meas_max=40, meas_owner=0.
- req0 and req1 high together from reset, both held:
  - grants gnt0 then gnt1 then gnt0.
  - meas_owner sequence 0,1,0; busy low for 1 cycle between measurements.
- log2_win=15 with LOG2_MAX_WIN=10, iq_rssi=32767 constant:
  - 1024 samples accumulated; meas_avg=32767, no overflow.
- iq_rssi=-5 for all window samples, log2_win=1:
  - meas_avg=0, meas_max=0.
- abort pulsed in the cycle of the last ACCUM sample:
  - no meas_done; busy low next cycle; previous meas_avg unchanged.
  - rst asserted mid-SETTLE -> all outputs 0 next cycle.
- RSSI_MEAS_TIMEOUT_EN, TIMEOUT_CYCLES=100, valid stops after 2 of 4 ACCUM samples (8,4):
  - meas_done with meas_timeout=1, meas_avg=3, meas_max=8.
